mfc_mean_sub: RTL and testbench

Streaming per-dimension mean subtraction for the DP_MFC feature path. Consumes MFC feature frames of WORDS signed samples over a valid/ready input and reads the matching per-dimension coefficient from the team's synchronous-read coefficient BRAM (one-cycle read latency, `addr`/`outdata`). It emits saturated `feature - coefficient` samples over a valid/ready output. It is the reader side of that BRAM; the parent ties the BRAM `write` input to 0 and `indata` to 0.

---
 rtl/mfc_mean_sub_if.sv | 27 ++
 rtl/mfc_mean_sub.sv | 82 ++++++++
 tb/tb_mfc_mean_sub.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mfc_mean_sub_if.sv
// mfc_mean_sub_if: stream-in, stream-out and coefficient BRAM read signals for mfc_mean_sub
interface mfc_mean_sub_if #(
    parameter int DWIDTH = 21,
    parameter int AWIDTH = 5
);
    logic                     clear;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DWIDTH-1:0] in_data;
    logic [AWIDTH-1:0]        mem_addr;
    logic signed [DWIDTH-1:0] mem_outdata;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DWIDTH-1:0] out_data;
    logic                     out_last;
    logic                     out_sat;

    modport master (
        output clear, in_valid, in_data, mem_outdata, out_ready,
        input  in_ready, mem_addr, out_valid, out_data, out_last, out_sat
    );

    modport slave (
        input  clear, in_valid, in_data, mem_outdata, out_ready,
        output in_ready, mem_addr, out_valid, out_data, out_last, out_sat
    );
endinterface

// File: rtl/mfc_mean_sub.sv
// mfc_mean_sub: streaming per-dimension mean subtraction against a coefficient BRAM
module mfc_mean_sub #(
    parameter int DWIDTH = 21,
    parameter int AWIDTH = 5,
    parameter int WORDS  = 24
) (
    input logic           clk,
    input logic           rst,
    mfc_mean_sub_if.slave bus
);
    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(WORDS - 1);

    logic [AWIDTH-1:0]        idx;
    logic [AWIDTH-1:0]        s1_idx;
    logic                     s1_valid;
    logic                     s1_adv;
    logic                     accept;
    logic                     ovf;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_sat;
    logic signed [DWIDTH-1:0] s1_data;
    logic signed [DWIDTH-1:0] out_data;
    logic signed [DWIDTH-1:0] clamped;
    logic signed [DWIDTH:0]   diff;

    assign s1_adv       = s1_valid && (!out_valid || bus.out_ready);
    assign bus.in_ready = !bus.clear && (!s1_valid || s1_adv);
    assign accept       = bus.in_valid && bus.in_ready;
    // A stalled stage 1 keeps re-reading its own entry so the BRAM output stays aligned with s1_data.
    assign bus.mem_addr = (s1_valid && !s1_adv) ? s1_idx : idx;
    assign diff         = {s1_data[DWIDTH-1], s1_data} - {bus.mem_outdata[DWIDTH-1], bus.mem_outdata};
    assign ovf          = diff[DWIDTH] != diff[DWIDTH-1];
    assign clamped      = !ovf ? diff[DWIDTH-1:0]
                        : diff[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bus.out_sat   = out_sat;

    // Frame index and stage 1 capture; a same-cycle accept and advance reloads stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_idx   <= '0;
        end else if (bus.clear) begin
            idx      <= '0;
            s1_valid <= 1'b0;
        end else if (accept) begin
            idx      <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            s1_valid <= 1'b1;
            s1_data  <= bus.in_data;
            s1_idx   <= idx;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Output register: saturated difference, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (bus.clear) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out_data  <= clamped;
            out_last  <= s1_idx == LAST_IDX;
            out_sat   <= ovf;
        end else if (out_valid && bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mfc_mean_sub.sv
// tb_mfc_mean_sub: randomized self-checking bench for mfc_mean_sub with a behavioural BRAM and model
module tb_mfc_mean_sub;
    typedef struct {
        logic signed [20:0] d;
        logic               l;
        logic               s;
        int                 cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [20:0] coef [32];
    logic signed [20:0] mem_q;
    exp_t q [$];
    exp_t e;
    int   midx = 0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic acc, got, e_ok, held_v, stab_chk;
    logic signed [20:0] in_d, a_d, held_d, stab_d;
    logic a_l, a_s;

    mfc_mean_sub_if #(.DWIDTH(21), .AWIDTH(5)) bus();

    mfc_mean_sub #(.DWIDTH(21), .AWIDTH(5), .WORDS(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_q <= coef[bus.mem_addr];
    assign bus.mem_outdata = mem_q;

    function automatic exp_t model(input logic signed [20:0] x, input int i);
        exp_t r;
        int diff, c;
        diff = int'(x) - int'(coef[i]);
        c = diff > 1048575 ? 1048575 : diff < -1048576 ? -1048576 : diff;
        r.d = 21'(c);
        r.l = i == 23;
        r.s = c != diff;
        r.cyc = cyc;
        return r;
    endfunction

    task automatic flush_model();
        q.delete();
        midx = 0;
        held_v = 1'b0;
    endtask

    // Advances one clock: samples handshakes at the negedge, updates the model after the posedge.
    task automatic step();
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        got = bus.out_valid && bus.out_ready;
        in_d = bus.in_data;
        a_d = bus.out_data;
        a_l = bus.out_last;
        a_s = bus.out_sat;
        stab_chk = held_v && bus.out_valid;
        stab_d = held_d;
        held_v = bus.out_valid && !bus.out_ready && !bus.clear;
        held_d = bus.out_data;
        @(posedge clk);
        cyc++;
        e_ok = 1'b0;
        if (got && q.size() > 0) begin
            e = q.pop_front();
            e_ok = 1'b1;
        end
        if (bus.clear) flush_model();
        else if (acc) begin
            q.push_back(model(in_d, midx));
            midx = (midx + 1) % 24;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        flush_model();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 21'sd0) begin errors++; $display("FAIL reset out_data got %0d want 0", bus.out_data); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset out_last got %b want 0", bus.out_last); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL reset out_sat got %b want 0", bus.out_sat); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.mem_addr !== 5'd0) begin errors++; $display("FAIL reset mem_addr got %0d want 0", bus.mem_addr); end
    endtask

    task automatic test_single_frame();
        int sent = 0, outs = 0, budget = 0;
        bus.out_ready = 1'b1;
        while (outs < 24 && budget < 200) begin
            bus.in_valid = sent < 24;
            bus.in_data = sent == 0 ? 21'sd241930 : 21'sd0;
            step();
            budget++;
            if (acc) sent++;
            if (got) begin
                checks++;
                if (!e_ok || a_d !== e.d || a_l !== e.l || a_s !== e.s || cyc - e.cyc != 2) begin
                    errors++;
                    $display("FAIL frame[%0d] got d=%0d l=%b s=%b want d=%0d l=%b s=%b, latency %0d want 2",
                             outs, a_d, a_l, a_s, e.d, e.l, e.s, cyc - e.cyc);
                end
                if (outs == 0) begin
                    checks++; if (a_d !== 21'sd0) begin errors++; $display("FAIL frame first got %0d want 0", a_d); end
                end
                if (outs == 1) begin
                    checks++; if (a_d !== -21'sd214839) begin errors++; $display("FAIL frame second got %0d want -214839", a_d); end
                end
                if (outs == 23) begin
                    checks++;
                    if (a_d !== -21'sd230322 || a_l !== 1'b1) begin errors++; $display("FAIL frame last got d=%0d l=%b want -230322 l=1", a_d, a_l); end
                end
                outs++;
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (outs != 24) begin errors++; $display("FAIL frame count got %0d want 24", outs); end
    endtask

    task automatic test_saturation();
        int sent = 0, outs = 0, budget = 0;
        bus.out_ready = 1'b1;
        while (outs < 2 && budget < 50) begin
            bus.in_valid = sent < 2;
            bus.in_data = sent == 0 ? -21'sd1048576 : 21'sd214839;
            step();
            budget++;
            if (acc) sent++;
            if (got) begin
                checks++;
                if (!e_ok || a_d !== e.d || a_s !== e.s) begin errors++; $display("FAIL sat model got d=%0d s=%b want d=%0d s=%b", a_d, a_s, e.d, e.s); end
                checks++;
                if (outs == 0 && (a_d !== -21'sd1048576 || a_s !== 1'b1)) begin errors++; $display("FAIL sat clamp got d=%0d s=%b want -1048576 s=1", a_d, a_s); end
                else if (outs == 1 && (a_d !== 21'sd0 || a_s !== 1'b0)) begin errors++; $display("FAIL sat next got d=%0d s=%b want 0 s=0", a_d, a_s); end
                outs++;
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (outs != 2) begin errors++; $display("FAIL sat count got %0d want 2", outs); end
        repeat (2) step();
    endtask

    task automatic test_back_to_back();
        int sent = 0, outs = 0, lasts = 0, budget = 0;
        logic signed [20:0] r;
        flush_model();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        while (outs < 72 && budget < 2000) begin
            if (!bus.in_valid || acc) begin
                case ($urandom_range(0, 3))
                    0: r = 21'sd1048575;
                    1: r = -21'sd1048576;
                    default: r = 21'($urandom);
                endcase
                bus.in_data = r;
            end
            bus.in_valid = sent < 72;
            bus.out_ready = $urandom_range(0, 1) == 1;
            step();
            budget++;
            if (acc) sent++;
            if (stab_chk) begin
                checks++;
                if (a_d !== stab_d) begin errors++; $display("FAIL stall stable got %0d want %0d", a_d, stab_d); end
            end
            if (got) begin
                checks++;
                if (!e_ok || a_d !== e.d || a_l !== e.l || a_s !== e.s || a_l !== (outs % 24 == 23)) begin
                    errors++;
                    $display("FAIL b2b[%0d] got d=%0d l=%b s=%b want d=%0d l=%b s=%b", outs, a_d, a_l, a_s, e.d, e.l, e.s);
                end
                if (a_l) lasts++;
                outs++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (outs != 72 || lasts != 3) begin errors++; $display("FAIL b2b count got %0d/%0d want 72/3", outs, lasts); end
        repeat (2) step();
        checks++; if (bus.mem_addr !== 5'd0) begin errors++; $display("FAIL b2b idx wrap mem_addr got %0d want 0", bus.mem_addr); end
    endtask

    task automatic test_clear();
        int sent = 0, budget = 0;
        logic seen = 1'b0;
        bus.out_ready = 1'b1;
        while (sent < 10 && budget < 100) begin
            bus.in_valid = 1'b1;
            bus.in_data = 21'($urandom);
            step();
            budget++;
            if (acc) sent++;
            if (got) begin
                checks++;
                if (!e_ok || a_d !== e.d) begin errors++; $display("FAIL clear pre got %0d want %0d", a_d, e.d); end
            end
        end
        bus.clear = 1'b1;
        bus.in_data = 21'sd77;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clear in_ready got %b want 0", bus.in_ready); end
        step();
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clear out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.mem_addr !== 5'd0) begin errors++; $display("FAIL clear mem_addr got %0d want 0", bus.mem_addr); end
        bus.in_valid = 1'b1;
        bus.in_data = 21'sd241935;
        budget = 0;
        while (!seen && budget < 20) begin
            step();
            budget++;
            if (acc) bus.in_valid = 1'b0;
            if (got) begin
                seen = 1'b1;
                checks++;
                if (a_d !== 21'sd5 || a_s !== 1'b0) begin errors++; $display("FAIL clear restart got d=%0d s=%b want 5 s=0", a_d, a_s); end
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL clear restart timeout got none want one output"); end
    endtask

    task automatic test_async_reset();
        int sent = 0, budget = 0;
        logic seen = 1'b0;
        bus.out_ready = 1'b0;
        while (sent < 2 && budget < 20) begin
            bus.in_valid = 1'b1;
            bus.in_data = 21'($urandom);
            step();
            budget++;
            if (acc) sent++;
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL full stall got in_ready=%b out_valid=%b want 0/1", bus.in_ready, bus.out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async rst out_valid got %b want 0", bus.out_valid); end
        flush_model();
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 21'sd241937;
        budget = 0;
        while (!seen && budget < 20) begin
            step();
            budget++;
            if (acc) bus.in_valid = 1'b0;
            if (got) begin
                seen = 1'b1;
                checks++;
                if (a_d !== 21'sd7 || !e_ok || a_d !== e.d) begin errors++; $display("FAIL async rst restart got %0d want 7", a_d); end
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL async rst timeout got none want one output"); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) coef[i] = 21'($urandom);
        coef[0] = 21'sd241930;
        coef[1] = 21'sd214839;
        coef[23] = 21'sd230322;
        held_v = 1'b0;
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_saturation();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
